// File: rtl/urv_ahb_imem_if.sv
// AHB-lite bus bundle between a fetch/system master and the urv_ahb_imem RAM slave.
interface urv_ahb_imem_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/urv_ahb_imem.sv
// urv_ahb_imem: AHB-lite single-port RAM slave for instruction fetch or general use.
// Byte-lane writes, programmable wait states, two-cycle ERROR response, and a
// write-to-read bypass so back-to-back transfers never stall.
module urv_ahb_imem #(
   parameter int unsigned g_size_words  = 4096,
   parameter logic [31:0] g_base_addr   = 32'h0000_0000,
   parameter int unsigned g_wait_states = 0
) (
   input  logic           clk_i,
   input  logic           rst_i,
   urv_ahb_imem_if.slave  bus
);

   localparam int unsigned c_aw    = $clog2(g_size_words);
   localparam logic [32:0] c_bytes = 33'(g_size_words) << 2;
   localparam logic [3:0]  c_ws    = 4'(g_wait_states);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} t_state;

   logic [31:0]     r_mem [g_size_words];
   t_state          r_state;
   t_state          w_next;
   logic [3:0]      r_cnt;
   logic            r_dp_valid;
   logic            r_dp_write;
   logic [c_aw-1:0] r_dp_idx;
   logic [3:0]      r_dp_lanes;
   logic [31:0]     r_hrdata;

   logic            w_accept;
   logic [31:0]     w_off;
   logic            w_in_range;
   logic            w_aligned;
   logic            w_legal;
   logic            w_acc_ok;
   logic [c_aw-1:0] w_idx;
   logic            w_dp_done;
   logic            w_we;
   logic [31:0]     w_rd_word;
   logic [31:0]     w_rd_byp;
   logic            w_unused;

   // Replace the byte lanes selected by i_lanes with the new data.
   function automatic logic [31:0] f_merge(input logic [31:0] i_old, input logic [31:0] i_new,
                                           input logic [3:0] i_lanes);
      logic [31:0] v;
      v = i_old;
      for (int i = 0; i < 4; i++) begin
         if (i_lanes[i]) v[8*i +: 8] = i_new[8*i +: 8];
      end
      return v;
   endfunction

   // Byte-lane enables from transfer size and low address bits.
   function automatic logic [3:0] f_lanes(input logic [2:0] i_size, input logic [1:0] i_a);
      case (i_size)
         3'd0:    return 4'b0001 << i_a;
         3'd1:    return 4'b0011 << i_a;
         default: return 4'b1111;
      endcase
   endfunction

   assign w_accept   = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
   assign w_off      = bus.HADDR - g_base_addr;
   assign w_in_range = (bus.HADDR >= g_base_addr) && ({1'b0, w_off} < c_bytes);
   assign w_aligned  = (bus.HSIZE == 3'd0) ||
                       ((bus.HSIZE == 3'd1) && !bus.HADDR[0]) ||
                       ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] == 2'b00));
   assign w_legal    = w_in_range && w_aligned;
   assign w_acc_ok   = w_accept && w_legal;
   assign w_idx      = w_off[c_aw+1:2];
   // A legal data phase finishes in the first IDLE cycle after its address phase.
   assign w_dp_done  = r_dp_valid && (r_state == S_IDLE);
   assign w_we       = w_dp_done && r_dp_write;
   assign w_rd_word  = r_mem[w_idx];
   // A read accepted on the edge that completes a write to the same word sees the new bytes.
   assign w_rd_byp   = (w_we && (r_dp_idx == w_idx)) ? f_merge(w_rd_word, bus.HWDATA, r_dp_lanes)
                                                     : w_rd_word;
   assign w_unused   = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, w_off};

   // State register.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic: ready states (IDLE, ERR2) may accept a new transfer.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_ERR2: begin
            w_next = S_IDLE;
            if (w_accept) begin
               if (!w_legal)          w_next = S_ERR1;
               else if (c_ws != 4'd0) w_next = S_WAIT;
            end
         end
         S_WAIT:  if (r_cnt == 4'd1) w_next = S_IDLE;
         S_ERR1:  w_next = S_ERR2;
         default: w_next = S_IDLE;
      endcase
   end

   // Output decode from state.
   always_comb begin
      bus.HREADYOUT = !((r_state == S_WAIT) || (r_state == S_ERR1));
      bus.HRESP     = (r_state == S_ERR1) || (r_state == S_ERR2);
      bus.HRDATA    = r_hrdata;
   end

   // Wait-state counter: loaded on a legal accept, counts down while waiting.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)                  r_cnt <= 4'd0;
      else if (w_acc_ok && (c_ws != 4'd0)) r_cnt <= c_ws;
      else if (r_state == S_WAIT)  r_cnt <= r_cnt - 4'd1;
   end

   // Pending data-phase control; reset drops any write still in flight.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_dp_valid <= 1'b0;
         r_dp_write <= 1'b0;
      end else if (w_accept) begin
         r_dp_valid <= w_legal;
         r_dp_write <= bus.HWRITE;
      end else if (w_dp_done) begin
         r_dp_valid <= 1'b0;
      end
   end

   // Pending data-phase payload (word index and lanes).
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_dp_idx   <= w_idx;
         r_dp_lanes <= f_lanes(bus.HSIZE, bus.HADDR[1:0]);
      end
   end

   // RAM write on the edge ending a write data phase.
   always_ff @(posedge clk_i) begin
      if (w_we) begin
         for (int i = 0; i < 4; i++) begin
            if (r_dp_lanes[i]) r_mem[r_dp_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
         end
      end
   end

   // Read data: at accept with no wait states, else on the last wait cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         r_hrdata <= 32'd0;
      else if ((c_ws == 4'd0) && w_acc_ok && !bus.HWRITE)
         r_hrdata <= w_rd_byp;
      else if ((r_state == S_WAIT) && (r_cnt == 4'd1) && r_dp_valid && !r_dp_write)
         r_hrdata <= r_mem[r_dp_idx];
   end

endmodule

// File: doc/urv_ahb_imem.md
Name: urv_ahb_imem

Overview:
- AHB-lite slave that serves the core's instruction-fetch master port (HADDR_I/HTRANS_I/HRDATA_I/HREADY_I/HRESP_I) from on-chip RAM.
- Single-port RAM with byte-lane writes, programmable wait states and a two-cycle ERROR response for illegal accesses.
- Also usable as a generic AHB-lite RAM on the system bus.
- Writes supported so a loader or debug master can preload code.

Parameters:
- g_size_words, 4096: RAM depth in 32-bit words (power of two).
- g_base_addr, 32'h0000_0000: byte base address; must be aligned to 4*g_size_words.
- g_wait_states, 0: extra data-phase cycles per OKAY transfer (0..15).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- HSEL  in  1  slave select; tie high for point-to-point
- HADDR  in  32  address phase byte address
- HTRANS  in  2  transfer type; bit1 set = NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word
- HBURST  in  3  ignored; each beat handled independently
- HPROT  in  4  ignored
- HMASTLOCK  in  1  ignored
- HWDATA  in  32  write data, data phase
- HREADY  in  1  bus ready; tie to HREADYOUT for point-to-point
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data

Behaviour:
- Accept: HSEL && HTRANS[1] && HREADY at a rising edge latches addr, write, size. IDLE/BUSY or !HSEL: no access, zero-wait OKAY.
- Illegal transfers:
  - address outside [g_base_addr, g_base_addr+4*g_size_words)
  - HSIZE > 2
  - half-word with HADDR[0]=1
  - word with HADDR[1:0]≠0
- States: IDLE, WAIT, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
  - legal accept with g_wait_states>0 -> WAIT, counter = g_wait_states.
  - legal accept with g_wait_states=0 -> data phase completes next cycle; stay IDLE.
  - illegal accept -> ERR1.
- WAIT: HREADYOUT=0, HRESP=0; counter decrements each cycle; at 1 -> IDLE, so the next cycle is the ready data-phase cycle.
- ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
- ERR2: HREADYOUT=1, HRESP=1 -> IDLE. No RAM access for the errored transfer. A transfer presented in ERR2 with HREADY=1 is accepted normally; a master cancel to IDLE is also legal.
- Read:
  - RAM word is read so HRDATA is valid in the cycle HREADYOUT=1 ends the data phase.
  - Zero waits: HRDATA valid the cycle after the address phase.
  - HRDATA always returns the full word regardless of HSIZE; it holds its last value otherwise.
- Write:
  - HWDATA sampled at the edge ending the data phase (HREADYOUT=1).
  - Byte lanes from size/addr[1:0]: byte -> 1<<a; half -> 3<<a; word -> 4'hF.
- Pipelining:
  - A next address phase overlapping the current ready data phase is accepted; back-to-back transfers at full rate.
  - Read accepted in the same edge as a completing write to the same word returns merged data (new bytes on written lanes).
  - Bypass is required; a stall is not permitted.
- Word index = (HADDR - g_base_addr)[log2(g_size_words)+1:2].
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, counter 0. RAM contents are not reset.
- Reset mid-transfer: the pending write is discarded and the data phase is abandoned.
- Simultaneous accept and ERR2 completion: the new transfer is processed; error state does not stick.

Test Plan:
- Reset: hold rst_i low with HTRANS=NONSEQ -> HREADYOUT=1, HRESP=0, HRDATA=0; no RAM change after release.
- g_wait_states=0: word write 32'hDEADBEEF @0x10, then read @0x10 -> HRDATA=32'hDEADBEEF one cycle after the read address phase; HREADYOUT never low.
- Byte write 8'hAA @0x13 (HWDATA=32'hAA00_0000), then word read @0x10 -> 32'hAAADBEEF. Half write 16'h1234 @0x12 -> then 32'h1234BEEF.
- g_wait_states=2: read @0x10 -> HREADYOUT low exactly 2 cycles, data and HREADYOUT=1 on the 3rd cycle. Back-to-back reads @0x10/0x14 -> each takes 3 cycles.
- Errors: read @g_base_addr+4*g_size_words, and word write @0x2 -> HRESP=1 with HREADYOUT 0 then 1, then OKAY. The following read @0x0 succeeds and the RAM is unchanged.
- Hazard and reset: write 32'h55AA55AA @0x20 pipelined with read @0x20 -> returns 32'h55AA55AA. Assert rst_i in WAIT of a write -> outputs at reset values, target word unchanged.
